icb_word_copier: RTL and testbench

ICB_WORD_COPIER -- requirements
Module: icb_word_copier

---
 rtl/icb_word_copier_pkg.sv | 22 ++
 rtl/icb_word_copier.sv | 108 ++++++++++
 tb/tb_icb_word_copier.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_word_copier_pkg.sv
// Shared definitions for the ICB word copier: FSM state encoding, write-mask
// constants and the word-address increment helper.
package icb_word_copier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_CMD = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_CMD = 3'd3,
    ST_WR_RSP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [3:0] WMASK_NONE = 4'b0000;
  localparam logic [3:0] WMASK_ALL  = 4'b1111;

  // Addresses are tracked as word indices, so +1 here is +4 bytes with 2^32 wrap.
  function automatic logic [29:0] next_word(input logic [29:0] w);
    return w + 30'd1;
  endfunction

endpackage

// File: rtl/icb_word_copier.sv
// Copies len_words 32-bit words from src_addr to dst_addr over an ICB initiator,
// one read/write pair at a time with a single transaction outstanding.
module icb_word_copier
  import icb_word_copier_pkg::*;
#(
  parameter int simulation_delay = 1,
  parameter int len_width        = 16
) (
  input  logic                 m_icb_aclk,
  input  logic                 m_icb_aresetn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [len_width-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          m_icb_cmd_addr,
  output logic                 m_icb_cmd_read,
  output logic [31:0]          m_icb_cmd_wdata,
  output logic [3:0]           m_icb_cmd_wmask,
  output logic                 m_icb_cmd_valid,
  input  logic                 m_icb_cmd_ready,
  input  logic [31:0]          m_icb_rsp_rdata,
  input  logic                 m_icb_rsp_err,
  input  logic                 m_icb_rsp_valid,
  output logic                 m_icb_rsp_ready
);

  state_e               state_q;
  logic [29:0]          src_q;
  logic [29:0]          dst_q;
  logic [len_width-1:0] rem_q;
  logic                 err_q;
  logic [31:0]          hold_q;

  always_ff @(posedge m_icb_aclk or negedge m_icb_aresetn) begin
    if (!m_icb_aresetn) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q   <= src_addr[31:2];
            dst_q   <= dst_addr[31:2];
            rem_q   <= len_words;
            err_q   <= 1'b0;
            state_q <= (len_words == '0) ? ST_DONE : ST_RD_CMD;
          end
        end
        ST_RD_CMD: begin
          if (m_icb_cmd_ready) state_q <= ST_RD_RSP;
        end
        ST_RD_RSP: begin
          if (m_icb_rsp_valid) begin
            if (m_icb_rsp_err) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WR_CMD;
            end
          end
        end
        ST_WR_CMD: begin
          if (m_icb_cmd_ready) state_q <= ST_WR_RSP;
        end
        ST_WR_RSP: begin
          if (m_icb_rsp_valid) begin
            if (m_icb_rsp_err) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              src_q   <= next_word(src_q);
              dst_q   <= next_word(dst_q);
              rem_q   <= rem_q - len_width'(1);
              state_q <= (rem_q == len_width'(1)) ? ST_DONE : ST_RD_CMD;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data is pure payload; it is always rewritten before the write uses it.
  always_ff @(posedge m_icb_aclk) begin
    if (state_q == ST_RD_RSP && m_icb_rsp_valid) hold_q <= m_icb_rsp_rdata;
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign err             = err_q;
  assign m_icb_cmd_valid = (state_q == ST_RD_CMD) || (state_q == ST_WR_CMD);
  assign m_icb_cmd_read  = (state_q == ST_RD_CMD);
  assign m_icb_cmd_addr  = (state_q == ST_WR_CMD) ? {dst_q, 2'b00} : {src_q, 2'b00};
  assign m_icb_cmd_wdata = hold_q;
  assign m_icb_cmd_wmask = (state_q == ST_WR_CMD) ? WMASK_ALL : WMASK_NONE;
  assign m_icb_rsp_ready = (state_q == ST_RD_RSP) || (state_q == ST_WR_RSP);

  logic unused_ok;
  assign unused_ok = (^{src_addr[1:0], dst_addr[1:0]}) ^ (simulation_delay != 0);

endmodule

// File: tb/tb_icb_word_copier.sv
// Scoreboard bench for icb_word_copier: a behavioural ICB slave checks every
// command against expected read/write transactions queued when a copy starts.
module tb_icb_word_copier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy, done, err;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_read, cmd_valid, cmd_ready;
  logic [3:0]  cmd_wmask;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_valid, rsp_ready;

  icb_word_copier #(.simulation_delay(1), .len_width(16)) dut (
    .m_icb_aclk      (clk),
    .m_icb_aresetn   (rst_n),
    .start           (start),
    .src_addr        (src_addr),
    .dst_addr        (dst_addr),
    .len_words       (len_words),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .m_icb_cmd_addr  (cmd_addr),
    .m_icb_cmd_read  (cmd_read),
    .m_icb_cmd_wdata (cmd_wdata),
    .m_icb_cmd_wmask (cmd_wmask),
    .m_icb_cmd_valid (cmd_valid),
    .m_icb_cmd_ready (cmd_ready),
    .m_icb_rsp_rdata (rsp_rdata),
    .m_icb_rsp_err   (rsp_err),
    .m_icb_rsp_valid (rsp_valid),
    .m_icb_rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rd_idx = 0;
  int   err_rd_idx = -1;
  int   stall_rd_idx = -1;
  int   stall_left = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  // Behavioural slave: ready decided mid-cycle, response one cycle after handshake.
  initial begin
    bit          hs_cmd, hs_rsp, nerr;
    logic [31:0] ndata;
    exp_t        e;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      hs_cmd = 1'b0;
      nerr   = 1'b0;
      ndata  = '0;
      hs_rsp = rsp_valid && rsp_ready;
      if (cmd_valid) begin
        if (cmd_read && rd_idx == stall_rd_idx && stall_left > 0) begin
          cmd_ready = 1'b0;
          stall_left--;
          if (sb.size() > 0) check_val("stall_addr", cmd_addr, sb[0].addr);
          check_val("stall_read", {31'd0, cmd_read}, 32'd1);
        end else begin
          cmd_ready = 1'b1;
          hs_cmd    = 1'b1;
        end
      end else begin
        cmd_ready = 1'b0;
      end
      if (hs_cmd) begin
        if (sb.size() == 0) begin
          check_val("unexpected_cmd", {31'd0, cmd_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("cmd_read", {31'd0, cmd_read}, {31'd0, e.rd});
          check_val("cmd_addr", cmd_addr, e.addr);
          check_val("cmd_wmask", {28'd0, cmd_wmask}, e.rd ? 32'h0 : 32'hF);
          if (!e.rd) check_val("cmd_wdata", cmd_wdata, e.data);
          if (e.rd) begin
            ndata = mem_fn(cmd_addr);
            nerr  = (rd_idx == err_rd_idx);
            rd_idx++;
          end
        end
      end
      @(posedge clk);
      #1;
      if (hs_rsp) begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
      end
      if (hs_cmd) begin
        rsp_valid = 1'b1;
        rsp_rdata = ndata;
        rsp_err   = nerr;
      end
    end
  end

  // Runs one copy; entered and left just after a rising edge.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                          input int err_idx, input int stall_idx, input bit poke);
    int          exp_lat, n;
    bit          seen;
    logic [31:0] ra, wa;
    for (int i = 0; i < len; i++) begin
      ra = {s[31:2], 2'b00} + 32'(4 * i);
      wa = {d[31:2], 2'b00} + 32'(4 * i);
      sb.push_back('{rd: 1'b1, addr: ra, data: 32'h0});
      if (i == err_idx) break;
      sb.push_back('{rd: 1'b0, addr: wa, data: mem_fn(ra)});
    end
    rd_idx       = 0;
    err_rd_idx   = err_idx;
    stall_rd_idx = stall_idx;
    stall_left   = (stall_idx >= 0) ? 5 : 0;
    exp_lat      = (err_idx >= 0) ? 4 * err_idx + 3 : 4 * len + 1 + stall_left;
    src_addr  = s;
    dst_addr  = d;
    len_words = 16'(len);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("busy_after_start", {31'd0, busy}, 32'd1);
    check_val("err_cleared", {31'd0, err}, 32'd0);
    n = 1;
    seen = 1'b0;
    while (n <= 300 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (poke && n == 3) begin
          start     = 1'b1;
          src_addr  = 32'hDEAD_0000;
          dst_addr  = 32'hBEEF_0000;
          len_words = 16'd7;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
        n++;
      end
    end
    start = 1'b0;
    check_val("done_seen", {31'd0, seen}, 32'd1);
    check_val("done_latency", 32'(n), 32'(exp_lat));
    check_val("busy_in_done", {31'd0, busy}, 32'd1);
    check_val("err_flag", {31'd0, err}, (err_idx >= 0) ? 32'd1 : 32'd0);
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    check_val("done_one_cycle", {31'd0, done}, 32'd0);
    check_val("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  hit;
    rst_n     = 1'b0;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_val("rst_rsp_ready", {31'd0, rsp_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_copy(32'h0000_0100, 32'h0000_0200, 4, -1, -1, 1'b1);
    run_copy(32'h0000_0500, 32'h0000_0600, 0, -1, -1, 1'b0);
    run_copy(32'h0000_1000, 32'h0000_2003, 3, -1, 1, 1'b0);
    run_copy(32'h0000_0700, 32'h0000_0800, 3, 1, -1, 1'b0);
    check_val("err_sticky", {31'd0, err}, 32'd1);
    run_copy(32'h0000_0040, 32'h0000_0080, 1, -1, -1, 1'b0);
    run_copy(32'hFFFF_FFFC, 32'h0000_0010, 2, -1, -1, 1'b0);

    // Asynchronous reset while a write command is waiting to be accepted.
    sb.push_back('{rd: 1'b1, addr: 32'h0000_0300, data: 32'h0});
    sb.push_back('{rd: 1'b0, addr: 32'h0000_0400, data: mem_fn(32'h0000_0300)});
    rd_idx = 0; err_rd_idx = -1; stall_rd_idx = -1; stall_left = 0;
    src_addr = 32'h0000_0300; dst_addr = 32'h0000_0400; len_words = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    hit = 1'b0;
    while (n < 50 && !hit) begin
      if (cmd_valid && !cmd_read) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check_val("reach_wr_cmd", {31'd0, hit}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("async_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_val("async_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_val("post_rst_busy", {31'd0, busy}, 32'd0);
      check_val("post_rst_valid", {31'd0, cmd_valid}, 32'd0);
    end
    check_val("post_rst_err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
